// File: rtl/io_monitor.sv
// io_monitor: debounced trigger pulse generator plus a small change-capture
// FIFO for the register file's a0 value, presented as a valid/ready stream.
module io_monitor #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_in,
  output logic                  trigger,
  input  logic [DATA_WIDTH-1:0] a0,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  // Button path state
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              stable_q, stable_d;
  logic              stable_dly_q, stable_dly_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              trigger_q, trigger_d;

  // a0 capture and FIFO state
  logic [DATA_WIDTH-1:0] prev_a0_q, prev_a0_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic push_req;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_ok;

  // Synchronize the raw button, then require DEBOUNCE_CYCLES agreeing samples
  // before the stable level follows; the trigger fires one cycle after a rise.
  always_comb begin
    sync1_d      = btn_in;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    dcnt_d       = '0;
    if (sync2_q != stable_q) begin
      if (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end
    stable_dly_d = stable_q;
    trigger_d    = stable_q & ~stable_dly_q;
  end

  // Detect a0 changes and compute FIFO push/pop bookkeeping; a push into a
  // full queue survives only when the head is leaving in the same cycle.
  always_comb begin
    push_req   = (a0 != prev_a0_q);
    prev_a0_d  = a0;
    fifo_empty = (fcnt_q == '0);
    fifo_full  = (fcnt_q == FCNT_W'(FIFO_DEPTH));
    pop        = ~fifo_empty & out_ready;
    push_ok    = push_req & (~fifo_full | pop);
    overflow_d = overflow_q | (push_req & fifo_full & ~pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fcnt_d     = fcnt_q;
    if (push_ok && !pop) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end else if (!push_ok && pop) begin
      fcnt_d = fcnt_q - FCNT_W'(1);
    end
  end

  // Storage write: only the tail slot changes, and only on an accepted push.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = a0;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      dcnt_q       <= '0;
      trigger_q    <= 1'b0;
      prev_a0_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      dcnt_q       <= dcnt_d;
      trigger_q    <= trigger_d;
      prev_a0_q    <= prev_a0_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcnt_q       <= fcnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage register; contents are meaningless while the count is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Outputs come straight from registers, so out_ready never reaches them.
  always_comb begin
    trigger   = trigger_q;
    overflow  = overflow_q;
    out_valid = ~fifo_empty;
    out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule
